// File: rtl/wand_pkg.sv
// Shared types and helpers for the wired-AND resolvers. The per-bit resolve
// function is written so that N-driver variants can reuse it.
package wand_pkg;

  localparam int CNT_W_DEFAULT = 8;

  // Which drivers are active on a bit, encoded as {en2, en1}.
  typedef enum logic [1:0] {
    DRV_NONE = 2'b00,
    DRV_1    = 2'b01,
    DRV_2    = 2'b10,
    DRV_BOTH = 2'b11
  } drv_state_e;

  typedef struct packed {
    logic value;
    logic z;
    logic conflict;
  } wand_res_t;

  function automatic drv_state_e drv_state(input logic en1, input logic en2);
    return drv_state_e'({en2, en1});
  endfunction

  function automatic wand_res_t wand_resolve(
    input logic i1,
    input logic i2,
    input logic en1,
    input logic en2,
    input logic z_value
  );
    wand_res_t res;
    res = '0;
    unique case (drv_state(en1, en2))
      DRV_BOTH: begin
        res.value    = i1 & i2;
        res.conflict = i1 ^ i2;
      end
      DRV_1:    res.value = i1;
      DRV_2:    res.value = i2;
      default: begin
        res.value = z_value;
        res.z     = 1'b1;
      end
    endcase
    return res;
  endfunction

endpackage

// File: rtl/wand_bit_resolve.sv
// Single-bit combinational wired-AND resolver; purely combinational so the
// enclosing block decides where the register boundary sits.
module wand_bit_resolve
  import wand_pkg::*;
#(
  parameter logic Z_VALUE = 1'b1
) (
  input  logic i1,
  input  logic i2,
  input  logic en1,
  input  logic en2,
  output logic r,
  output logic z,
  output logic c
);

  wand_res_t res;

  always_comb begin
    res = wand_resolve(i1, i2, en1, en2, Z_VALUE);
    r   = res.value;
    z   = res.z;
    c   = res.conflict;
  end

endmodule

// File: rtl/wand_1.sv
// Registered two-driver wired-AND net resolver with undriven/conflict flags
// and a saturating conflict-cycle counter. No handshake: every input is
// sampled on every rising clk edge and all outputs update one cycle later.
module wand_1
  import wand_pkg::*;
#(
  parameter int   WIDTH   = 1,
  parameter int   CNT_W   = CNT_W_DEFAULT,
  parameter logic Z_VALUE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] en1,
  input  logic [WIDTH-1:0] en2,
  output logic [WIDTH-1:0] o,
  output logic [WIDTH-1:0] o_z,
  output logic [WIDTH-1:0] conflict,
  output logic [CNT_W-1:0] conflict_cnt
);

  logic [WIDTH-1:0] o_nxt;
  logic [WIDTH-1:0] z_nxt;
  logic [WIDTH-1:0] conflict_nxt;

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    wand_bit_resolve #(
      .Z_VALUE(Z_VALUE)
    ) u_bit (
      .i1 (i1[b]),
      .i2 (i2[b]),
      .en1(en1[b]),
      .en2(en2[b]),
      .r  (o_nxt[b]),
      .z  (z_nxt[b]),
      .c  (conflict_nxt[b])
    );
  end

  // Counter holds at all-ones rather than wrapping.
  logic cnt_sat;
  assign cnt_sat = &conflict_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      o            <= '0;
      o_z          <= '0;
      conflict     <= '0;
      conflict_cnt <= '0;
    end else begin
      o        <= o_nxt;
      o_z      <= z_nxt;
      conflict <= conflict_nxt;
      if (|conflict_nxt && !cnt_sat) begin
        conflict_cnt <= conflict_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wand_1.sv
// Directed bench for wand_1: a 1-bit/8-bit-counter instance, a 1-bit/2-bit-counter
// instance sharing its stimulus, and a 4-bit instance for mixed-bit vectors.
module tb_wand_1;

  logic clk = 1'b0;
  logic rst;

  // Narrow instances (a: CNT_W=8, b: CNT_W=2) share one stimulus set.
  logic       i1, i2, en1, en2;
  logic       o_a, z_a, c_a;
  logic [7:0] cnt_a;
  logic       o_b, z_b, c_b;
  logic [1:0] cnt_b;

  // Wide instance.
  logic [3:0] w_i1, w_i2, w_en1, w_en2;
  logic [3:0] o_c, z_c, c_c;
  logic [7:0] cnt_c;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wand_1 #(.WIDTH(1), .CNT_W(8), .Z_VALUE(1'b1)) dut_a (
    .clk(clk), .rst(rst), .i1(i1), .i2(i2), .en1(en1), .en2(en2),
    .o(o_a), .o_z(z_a), .conflict(c_a), .conflict_cnt(cnt_a)
  );

  wand_1 #(.WIDTH(1), .CNT_W(2), .Z_VALUE(1'b1)) dut_b (
    .clk(clk), .rst(rst), .i1(i1), .i2(i2), .en1(en1), .en2(en2),
    .o(o_b), .o_z(z_b), .conflict(c_b), .conflict_cnt(cnt_b)
  );

  wand_1 #(.WIDTH(4), .CNT_W(8), .Z_VALUE(1'b1)) dut_c (
    .clk(clk), .rst(rst), .i1(w_i1), .i2(w_i2), .en1(w_en1), .en2(w_en2),
    .o(o_c), .o_z(z_c), .conflict(c_c), .conflict_cnt(cnt_c)
  );

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_n(input logic v1, input logic v2, input logic e1, input logic e2);
    i1 = v1; i2 = v2; en1 = e1; en2 = e2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_n(1'b1, 1'b1, 1'b1, 1'b1);
    w_i1 = '1; w_i2 = '1; w_en1 = '1; w_en2 = '1;
    tick();
    tick();
    n_cmp++; if (o_a !== 1'b0)   begin n_err++; $display("FAIL reset_o: got %b want 0", o_a); end
    n_cmp++; if (z_a !== 1'b0)   begin n_err++; $display("FAIL reset_o_z: got %b want 0", z_a); end
    n_cmp++; if (c_a !== 1'b0)   begin n_err++; $display("FAIL reset_conflict: got %b want 0", c_a); end
    n_cmp++; if (cnt_a !== 8'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", cnt_a); end
    n_cmp++; if (o_c !== 4'b0000) begin n_err++; $display("FAIL reset_o_wide: got %b want 0000", o_c); end
    rst = 1'b0;
  endtask

  task automatic test_truth_table();
    logic [1:0] vec    [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic       exp_o  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic       exp_c  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      drive_n(vec[k][1], vec[k][0], 1'b1, 1'b1);
      tick();
      n_cmp++;
      if (o_a !== exp_o[k]) begin
        n_err++; $display("FAIL tt_o[%0d]: got %b want %b", k, o_a, exp_o[k]);
      end
      n_cmp++;
      if (c_a !== exp_c[k]) begin
        n_err++; $display("FAIL tt_conflict[%0d]: got %b want %b", k, c_a, exp_c[k]);
      end
    end
    n_cmp++; if (cnt_a !== 8'd2) begin n_err++; $display("FAIL tt_cnt: got %0d want 2", cnt_a); end
  endtask

  task automatic test_undriven();
    drive_n(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    n_cmp++; if (o_a !== 1'b1) begin n_err++; $display("FAIL undriven_o: got %b want 1", o_a); end
    n_cmp++; if (z_a !== 1'b1) begin n_err++; $display("FAIL undriven_o_z: got %b want 1", z_a); end
    n_cmp++; if (c_a !== 1'b0) begin n_err++; $display("FAIL undriven_conflict: got %b want 0", c_a); end
    drive_n(1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    n_cmp++; if (o_a !== 1'b0) begin n_err++; $display("FAIL single_drv_o: got %b want 0", o_a); end
    n_cmp++; if (z_a !== 1'b0) begin n_err++; $display("FAIL single_drv_o_z: got %b want 0", z_a); end
    drive_n(1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    n_cmp++; if (o_a !== 1'b0) begin n_err++; $display("FAIL drv2_only_o: got %b want 0", o_a); end
    n_cmp++; if (cnt_a !== 8'd2) begin n_err++; $display("FAIL undriven_cnt: got %0d want 2", cnt_a); end
  endtask

  task automatic test_counter();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive_n(1'b0, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) tick();
    n_cmp++; if (cnt_a !== 8'd3) begin n_err++; $display("FAIL cnt_three: got %0d want 3", cnt_a); end
    n_cmp++; if (cnt_b !== 2'd3) begin n_err++; $display("FAIL cnt_narrow_three: got %0d want 3", cnt_b); end
    tick();
    tick();
    n_cmp++; if (cnt_a !== 8'd5) begin n_err++; $display("FAIL cnt_five: got %0d want 5", cnt_a); end
    n_cmp++; if (cnt_b !== 2'd3) begin n_err++; $display("FAIL cnt_saturate: got %0d want 3", cnt_b); end
    n_cmp++; if (c_b !== 1'b1)   begin n_err++; $display("FAIL sat_conflict: got %b want 1", c_b); end
    drive_n(1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    n_cmp++; if (c_b !== 1'b0)   begin n_err++; $display("FAIL sat_conflict_clear: got %b want 0", c_b); end
    n_cmp++; if (cnt_b !== 2'd3) begin n_err++; $display("FAIL sat_hold: got %0d want 3", cnt_b); end
    n_cmp++; if (o_b !== 1'b1)   begin n_err++; $display("FAIL agree_o: got %b want 1", o_b); end
  endtask

  task automatic test_mixed();
    // b3: drv1 only -> 1; b2,b1: both, disagree -> 0 + conflict; b0: drv1 only -> 0.
    w_i1 = 4'b1100; w_i2 = 4'b1010; w_en1 = 4'b1111; w_en2 = 4'b0110;
    tick();
    n_cmp++; if (o_c !== 4'b1000) begin n_err++; $display("FAIL mixed_o: got %b want 1000", o_c); end
    n_cmp++; if (c_c !== 4'b0110) begin n_err++; $display("FAIL mixed_conflict: got %b want 0110", c_c); end
    n_cmp++; if (z_c !== 4'b0000) begin n_err++; $display("FAIL mixed_o_z: got %b want 0000", z_c); end
    // b3 undriven, b2 both agree on 1, b1 drv2 only 1, b0 drv1 only 1.
    w_i1 = 4'b0101; w_i2 = 4'b0110; w_en1 = 4'b0101; w_en2 = 4'b0110;
    tick();
    n_cmp++; if (o_c !== 4'b1111) begin n_err++; $display("FAIL mixed2_o: got %b want 1111", o_c); end
    n_cmp++; if (z_c !== 4'b1000) begin n_err++; $display("FAIL mixed2_o_z: got %b want 1000", z_c); end
    n_cmp++; if (c_c !== 4'b0000) begin n_err++; $display("FAIL mixed2_conflict: got %b want 0000", c_c); end
  endtask

  task automatic test_reset_mid();
    drive_n(1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    n_cmp++; if (c_a !== 1'b1) begin n_err++; $display("FAIL pre_rst_conflict: got %b want 1", c_a); end
    rst = 1'b1;
    tick();
    n_cmp++; if (c_a !== 1'b0)   begin n_err++; $display("FAIL mid_rst_conflict: got %b want 0", c_a); end
    n_cmp++; if (cnt_a !== 8'd0) begin n_err++; $display("FAIL mid_rst_cnt: got %0d want 0", cnt_a); end
    n_cmp++; if (o_c !== 4'b0000) begin n_err++; $display("FAIL mid_rst_o_wide: got %b want 0000", o_c); end
    rst = 1'b0;
    tick();
    n_cmp++; if (c_a !== 1'b1)   begin n_err++; $display("FAIL post_rst_conflict: got %b want 1", c_a); end
    n_cmp++; if (cnt_a !== 8'd1) begin n_err++; $display("FAIL post_rst_cnt: got %0d want 1", cnt_a); end
    n_cmp++; if (o_c !== 4'b1111) begin n_err++; $display("FAIL post_rst_o_wide: got %b want 1111", o_c); end
  endtask

  initial begin
    rst = 1'b1;
    drive_n(1'b0, 1'b0, 1'b0, 1'b0);
    w_i1 = '0; w_i2 = '0; w_en1 = '0; w_en2 = '0;
    #1;
    test_reset();
    test_truth_table();
    test_undriven();
    test_counter();
    test_mixed();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
